// File: rtl/clkgen_seq_if.sv
// Control/status bundle between the clock-generation sequencer and its environment:
// enable and raw DCM lock inputs in, DCM reset, divider enable and status out.
interface clkgen_seq_if;
  logic       en;
  logic       locked1;
  logic       locked2;
  logic       dcm_rst;
  logic       div_en;
  logic       clk_ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  modport master (
    output en, locked1, locked2,
    input  dcm_rst, div_en, clk_ready, fail, retry_cnt, lock_loss_cnt, state
  );

  modport slave (
    input  en, locked1, locked2,
    output dcm_rst, div_en, clk_ready, fail, retry_cnt, lock_loss_cnt, state
  );
endinterface

// File: rtl/clkgen_seq_ctrl.sv
// Power-up and lock-supervision sequencer for the DCM pair: holds DCM reset, waits
// for both locks, settles, then enables the divided clocks; bounded retry on failure.
module clkgen_seq_ctrl #(
  parameter int RST_CYCLES    = 3,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRY     = 3,
  parameter int CW            = 16
) (
  input  logic         clk,
  input  logic         reset,
  clkgen_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_HOLD  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES) - CNT_ONE;
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT) - CNT_ONE;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES) - CNT_ONE;
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  logic          lk1_meta_r, lk1_sync_r, lk2_meta_r, lk2_sync_r;
  logic          lk_s;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    retry_r, retry_s;
  logic [7:0]    loss_r, loss_s;
  logic          retry_full_s;
  logic          dcm_rst_r, dcm_rst_s;
  logic          div_en_r, clk_ready_r, run_s;
  logic          fail_r, fail_s;

  assign lk_s         = lk1_sync_r & lk2_sync_r;
  assign retry_full_s = (retry_r == RETRY_MAX);

  // Next-state, counter and retry/loss bookkeeping; en=0 overrides every transition.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    retry_s = retry_r;
    loss_s  = loss_r;
    if (!bus.en) begin
      state_s = ST_IDLE;
      cnt_s   = '0;
      retry_s = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_RST_HOLD;
          cnt_s   = '0;
        end
        ST_RST_HOLD: begin
          if (cnt_r == RST_LAST) begin
            state_s = ST_WAIT_LOCK;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state_s = ST_SETTLE;
            cnt_s   = '0;
          end else if (cnt_r == TMO_LAST) begin
            state_s = retry_full_s ? ST_FAIL : ST_RST_HOLD;
            retry_s = retry_full_s ? retry_r : retry_r + 4'd1;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_SETTLE: begin
          // Any dropout during settling counts as a failed attempt.
          if (!lk_s) begin
            state_s = retry_full_s ? ST_FAIL : ST_RST_HOLD;
            retry_s = retry_full_s ? retry_r : retry_r + 4'd1;
            cnt_s   = '0;
          end else if (cnt_r == SETTLE_LAST) begin
            state_s = ST_RUN;
            retry_s = 4'd0;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state_s = ST_RST_HOLD;
            cnt_s   = '0;
            loss_s  = (loss_r == 8'hFF) ? loss_r : loss_r + 8'd1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_s = ST_FAIL;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Moore output decode from the next state so outputs move with the state register.
  always_comb begin
    dcm_rst_s = 1'b1;
    run_s     = 1'b0;
    fail_s    = 1'b0;
    case (state_s)
      ST_IDLE, ST_RST_HOLD: begin
        dcm_rst_s = 1'b1;
      end
      ST_WAIT_LOCK, ST_SETTLE: begin
        dcm_rst_s = 1'b0;
      end
      ST_RUN: begin
        dcm_rst_s = 1'b0;
        run_s     = 1'b1;
      end
      ST_FAIL: begin
        dcm_rst_s = 1'b1;
        fail_s    = 1'b1;
      end
      default: begin
        dcm_rst_s = 1'b1;
      end
    endcase
  end

  // Lock synchronizers, state/counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk1_meta_r  <= 1'b0;
      lk1_sync_r  <= 1'b0;
      lk2_meta_r  <= 1'b0;
      lk2_sync_r  <= 1'b0;
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      retry_r     <= 4'd0;
      loss_r      <= 8'd0;
      dcm_rst_r   <= 1'b1;
      div_en_r    <= 1'b0;
      clk_ready_r <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      lk1_meta_r  <= bus.locked1;
      lk1_sync_r  <= lk1_meta_r;
      lk2_meta_r  <= bus.locked2;
      lk2_sync_r  <= lk2_meta_r;
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      retry_r     <= retry_s;
      loss_r      <= loss_s;
      dcm_rst_r   <= dcm_rst_s;
      div_en_r    <= run_s;
      clk_ready_r <= run_s;
      fail_r      <= fail_s;
    end
  end

  assign bus.dcm_rst       = dcm_rst_r;
  assign bus.div_en        = div_en_r;
  assign bus.clk_ready     = clk_ready_r;
  assign bus.fail          = fail_r;
  assign bus.retry_cnt     = retry_r;
  assign bus.lock_loss_cnt = loss_r;
  assign bus.state         = state_r;

endmodule
